// File: rtl/except_ctrl.sv
// except_ctrl: picks one exception or interrupt from the MEM stage and runs the
// flush sequence for it. On a taken event it raises a one-cycle event code to
// CP0, holds flush for FLUSH_CYCLES cycles, and redirects the PC to the handler
// (or to EPC for eret). Stall requests are decoded to per-stage stalls while idle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   int_i, timer_int_i  level interrupt lines (timer is ORed into line 5)
//   cp0_status_i        Status: bit0 IE, bit1 EXL, bits 15:10 IM
//   cp0_epc_i           EPC, the return target for eret
//   mem_excepttype_i    raw MEM-stage flags (bits 12:8)
//   mem_inst_valid_i    MEM stage holds a real instruction
//   stallreq_id_i/ex_i  stall requests from ID and EX
//   excepttype_o        event code to CP0, one cycle per event (registered)
//   flush_o, new_pc_o   pipeline flush and redirect target (registered)
//   stall_o             {wb,mem,ex,id,if,pc} stalls (combinational)
//   busy_o              high while a flush sequence is in progress (registered)
module except_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] HANDLER_VEC  = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] mem_excepttype_i,
    input  logic        mem_inst_valid_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    output logic [31:0] excepttype_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o,
    output logic        busy_o
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STALL_W = 6;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               HAS_DRAIN = (FLUSH_CYCLES > 1);

    localparam logic [XLEN-1:0] EXC_NONE  = XLEN'(32'h0);
    localparam logic [XLEN-1:0] EXC_INT   = XLEN'(32'h1);
    localparam logic [XLEN-1:0] EXC_SYS   = XLEN'(32'h8);
    localparam logic [XLEN-1:0] EXC_INV   = XLEN'(32'ha);
    localparam logic [XLEN-1:0] EXC_TRAP  = XLEN'(32'hd);
    localparam logic [XLEN-1:0] EXC_OVF   = XLEN'(32'hc);
    localparam logic [XLEN-1:0] EXC_ERET  = XLEN'(32'he);

    localparam logic [STALL_W-1:0] STALL_EX = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID = STALL_W'(6'b000111);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAKE  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  exc_q, exc_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             busy_q, busy_d;

    logic [5:0]       irq_lines;
    logic             irq_pend;
    logic [XLEN-1:0]  event_code;

    // Status/flag bits this block does not look at.
    logic unused_bits;
    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[9:2],
                           mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

    // Interrupt pending: enabled, not already in an exception, and unmasked.
    assign irq_lines = int_i | {timer_int_i, 5'b0};
    assign irq_pend  = cp0_status_i[0] & ~cp0_status_i[1]
                     & (|(irq_lines & cp0_status_i[15:10]));

    // Fixed-priority encoder; lower-priority sources are simply dropped.
    always_comb begin
        event_code = EXC_NONE;
        if (irq_pend)                 event_code = EXC_INT;
        else if (mem_excepttype_i[8])  event_code = EXC_SYS;
        else if (mem_excepttype_i[9])  event_code = EXC_INV;
        else if (mem_excepttype_i[10]) event_code = EXC_TRAP;
        else if (mem_excepttype_i[11]) event_code = EXC_OVF;
        else if (mem_excepttype_i[12]) event_code = EXC_ERET;
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exc_d   = EXC_NONE;
        flush_d = 1'b0;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (mem_inst_valid_i && (event_code != EXC_NONE)) begin
                    state_d = TAKE;
                    exc_d   = event_code;
                    flush_d = 1'b1;
                    cnt_d   = '0;
                    pc_d    = (event_code == EXC_ERET) ? cp0_epc_i : HANDLER_VEC;
                end
            end
            TAKE: begin
                if (HAS_DRAIN) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(1);
                    flush_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // cnt_q counts flush cycles already issued after TAKE's one.
                if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exc_q   <= '0;
            flush_q <= 1'b0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            flush_q <= flush_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
        end
    end

    // Stalls only while idle; a flush in progress overrides any stall request.
    always_comb begin
        stall_o = '0;
        if (rst && (state_q == IDLE)) begin
            if (stallreq_ex_i)      stall_o = STALL_EX;
            else if (stallreq_id_i) stall_o = STALL_ID;
        end
    end

    assign excepttype_o = exc_q;
    assign flush_o      = flush_q;
    assign new_pc_o     = pc_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Testbench for except_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-count reference model of the flush sequence.
module tb_except_ctrl;

    localparam int unsigned FC = 2;
    localparam logic [31:0] HV = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_epc_i;
    logic [31:0] mem_excepttype_i;
    logic        mem_inst_valid_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [31:0] excepttype_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [5:0]  stall_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining flush cycles, code of the event, its target.
    int          m_left;
    bit          m_first;
    logic [31:0] m_exc;
    logic [31:0] m_pc;

    except_ctrl #(.FLUSH_CYCLES(FC), .HANDLER_VEC(HV)) dut (
        .clk              (clk),
        .rst              (rst),
        .int_i            (int_i),
        .timer_int_i      (timer_int_i),
        .cp0_status_i     (cp0_status_i),
        .cp0_epc_i        (cp0_epc_i),
        .mem_excepttype_i (mem_excepttype_i),
        .mem_inst_valid_i (mem_inst_valid_i),
        .stallreq_id_i    (stallreq_id_i),
        .stallreq_ex_i    (stallreq_ex_i),
        .excepttype_o     (excepttype_o),
        .flush_o          (flush_o),
        .new_pc_o         (new_pc_o),
        .stall_o          (stall_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_event();
        logic [5:0] lines;
        lines = int_i | {timer_int_i, 5'b0};
        if (cp0_status_i[0] && !cp0_status_i[1] && ((lines & cp0_status_i[15:10]) != 6'd0))
            return 32'h1;
        if (mem_excepttype_i[8])  return 32'h8;
        if (mem_excepttype_i[9])  return 32'ha;
        if (mem_excepttype_i[10]) return 32'hd;
        if (mem_excepttype_i[11]) return 32'hc;
        if (mem_excepttype_i[12]) return 32'he;
        return 32'h0;
    endfunction

    function automatic logic [5:0] ref_stall();
        if (!rst || m_left != 0) return 6'd0;
        if (stallreq_ex_i) return 6'b001111;
        if (stallreq_id_i) return 6'b000111;
        return 6'd0;
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_first = 0;
        m_exc   = 32'h0;
        m_pc    = 32'h0;
    endtask

    // Advance one rising edge, update the model from the inputs seen there.
    task automatic tick();
        logic [31:0] ev;
        @(posedge clk);
        if (rst) begin
            if (m_left == 0) begin
                m_first = 0;
                ev = ref_event();
                if (mem_inst_valid_i && ev != 32'h0) begin
                    m_left  = FC;
                    m_first = 1;
                    m_exc   = ev;
                    m_pc    = (ev == 32'he) ? cp0_epc_i : HV;
                end
            end else begin
                m_left  = m_left - 1;
                m_first = 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        int_i            = 6'd0;
        timer_int_i      = 1'b0;
        cp0_status_i     = 32'h0;
        cp0_epc_i        = 32'h0;
        mem_excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        stallreq_id_i    = 1'b0;
        stallreq_ex_i    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        stallreq_ex_i = 1'b1;
        mem_inst_valid_i = 1'b1;
        mem_excepttype_i = 32'h100;
        rst = 1'b0;
        model_reset();
        #2;
        checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL reset_exc: got %h want 0", excepttype_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", new_pc_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (stall_o !== 6'd0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (flush_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle: flush %b busy %b want 0 0", flush_o, busy_o); end
    endtask

    task automatic test_syscall();
        clear_inputs();
        mem_excepttype_i = 32'h100;
        mem_inst_valid_i = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL sys_exc: got %h want 8", excepttype_o); end
        checks++; if (new_pc_o !== 32'h20) begin errors++; $display("FAIL sys_pc: got %h want 20", new_pc_o); end
        checks++; if (flush_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL sys_c1: flush %b busy %b want 1 1", flush_o, busy_o); end
        tick();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL sys_exc2: got %h want 0", excepttype_o); end
        checks++; if (flush_o !== 1'b1 || busy_o !== 1'b1 || new_pc_o !== 32'h20) begin errors++; $display("FAIL sys_c2: flush %b busy %b pc %h want 1 1 20", flush_o, busy_o, new_pc_o); end
        tick();
        @(negedge clk);
        checks++; if (flush_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL sys_end: flush %b busy %b want 0 0", flush_o, busy_o); end
    endtask

    task automatic test_priority();
        clear_inputs();
        int_i            = 6'b000100;
        cp0_status_i     = 32'h0000_1001;
        mem_excepttype_i = 32'h900;
        mem_inst_valid_i = 1'b1;
        tick();
        // New event offered during TAKE and DRAIN must be ignored.
        int_i = 6'd0;
        cp0_status_i = 32'h0;
        mem_excepttype_i = 32'h800;
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL prio_exc: got %h want 1", excepttype_o); end
        tick();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b1) begin errors++; $display("FAIL prio_drain: exc %h flush %b want 0 1", excepttype_o, flush_o); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin errors++; $display("FAIL prio_nosecond: exc %h flush %b want 0 0", excepttype_o, flush_o); end
        tick();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0 || busy_o !== 1'b0) begin errors++; $display("FAIL prio_idle: exc %h busy %b want 0 0", excepttype_o, busy_o); end
    endtask

    task automatic test_masking();
        clear_inputs();
        int_i            = 6'b000100;
        cp0_status_i     = 32'h0000_1003;
        mem_inst_valid_i = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin errors++; $display("FAIL mask_exl: exc %h flush %b want 0 0", excepttype_o, flush_o); end
        cp0_status_i     = 32'h0000_1001;
        mem_inst_valid_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin errors++; $display("FAIL mask_invalid: exc %h flush %b want 0 0", excepttype_o, flush_o); end
        clear_inputs();
    endtask

    task automatic test_eret();
        clear_inputs();
        cp0_epc_i        = 32'h0000_1234;
        mem_excepttype_i = 32'h1000;
        mem_inst_valid_i = 1'b1;
        tick();
        clear_inputs();
        cp0_epc_i = 32'hdead_beef;
        @(negedge clk);
        checks++; if (excepttype_o !== 32'he || new_pc_o !== 32'h1234 || flush_o !== 1'b1) begin errors++; $display("FAIL eret_c1: exc %h pc %h flush %b want e 1234 1", excepttype_o, new_pc_o, flush_o); end
        tick();
        @(negedge clk);
        checks++; if (new_pc_o !== 32'h1234 || flush_o !== 1'b1) begin errors++; $display("FAIL eret_c2: pc %h flush %b want 1234 1", new_pc_o, flush_o); end
        tick();
    endtask

    task automatic test_stall();
        clear_inputs();
        stallreq_ex_i = 1'b1;
        stallreq_id_i = 1'b1;
        @(negedge clk);
        checks++; if (stall_o !== 6'b001111) begin errors++; $display("FAIL stall_ex: got %b want 001111", stall_o); end
        stallreq_ex_i = 1'b0;
        #1;
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL stall_id: got %b want 000111", stall_o); end
        mem_excepttype_i = 32'h100;
        mem_inst_valid_i = 1'b1;
        #1;
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL stall_with_event: got %b want 000111", stall_o); end
        tick();
        mem_excepttype_i = 32'h0;
        @(negedge clk);
        checks++; if (stall_o !== 6'd0 || excepttype_o !== 32'h8) begin errors++; $display("FAIL stall_take: stall %b exc %h want 0 8", stall_o, excepttype_o); end
        tick();
        @(negedge clk);
        checks++; if (stall_o !== 6'd0 || flush_o !== 1'b1) begin errors++; $display("FAIL stall_drain: stall %b flush %b want 0 1", stall_o, flush_o); end
        tick();
        @(negedge clk);
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL stall_after: got %b want 000111", stall_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_drain();
        clear_inputs();
        mem_excepttype_i = 32'h100;
        mem_inst_valid_i = 1'b1;
        tick();
        clear_inputs();
        tick();
        stallreq_id_i = 1'b1;
        #2;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rmd_pre: flush %b want 1", flush_o); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (flush_o !== 1'b0 || busy_o !== 1'b0 || stall_o !== 6'd0 || new_pc_o !== 32'h0) begin errors++; $display("FAIL rmd_async: flush %b busy %b stall %b pc %h want 0 0 0 0", flush_o, busy_o, stall_o, new_pc_o); end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        mem_excepttype_i = 32'h800;
        mem_inst_valid_i = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (excepttype_o !== 32'hc || flush_o !== 1'b1) begin errors++; $display("FAIL rmd_ovf: exc %h flush %b want c 1", excepttype_o, flush_o); end
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int_i            = 6'($urandom);
            timer_int_i      = ($urandom_range(0, 3) == 0);
            cp0_status_i     = {16'h0, 6'($urandom), 8'h0, 2'($urandom)};
            cp0_epc_i        = $urandom;
            mem_inst_valid_i = ($urandom_range(0, 3) != 0);
            mem_excepttype_i = ($urandom_range(0, 2) == 0) ? (32'($urandom_range(0, 31)) << 8) : 32'h0;
            stallreq_id_i    = $urandom_range(0, 1) == 1;
            stallreq_ex_i    = $urandom_range(0, 3) == 0;
            @(negedge clk);
            checks++;
            if (excepttype_o !== (m_first ? m_exc : 32'h0) || flush_o !== (m_left > 0)
                || busy_o !== (m_left > 0) || stall_o !== ref_stall()
                || (m_left > 0 && new_pc_o !== m_pc)) begin
                errors++;
                $display("FAIL rand_%0d: exc %h flush %b busy %b stall %b pc %h want %h %b %b %b %h",
                         i, excepttype_o, flush_o, busy_o, stall_o, new_pc_o,
                         (m_first ? m_exc : 32'h0), (m_left > 0), (m_left > 0), ref_stall(), m_pc);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        test_reset();
        test_syscall();
        test_priority();
        test_masking();
        test_eret();
        test_stall();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high per taken event (legal 1..7).
REQ-002 Parameter HANDLER_VEC, default 32'h00000020, exception handler entry address.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 int_i  in  6  external interrupt lines, level.
REQ-006 timer_int_i  in  1  timer interrupt, level, ORed into line 5.
REQ-007 cp0_status_i  in  32  current Status; bit0 IE, bit1 EXL, bits 15:10 IM.
REQ-008 cp0_epc_i  in  32  current EPC.
REQ-009 mem_excepttype_i  in  32  raw MEM-stage flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
REQ-010 mem_inst_valid_i  in  1  MEM stage holds a real instruction.
REQ-011 stallreq_id_i, stallreq_ex_i  in  1 each  stall requests.
REQ-012 excepttype_o  out  32  encoded event to CP0, nonzero for exactly one cycle per event.
REQ-013 flush_o  out  1  pipeline flush.
REQ-014 new_pc_o  out  32  redirect target, valid while flush_o=1.
REQ-015 stall_o  out  6  per-stage stall {wb,mem,ex,id,if,pc} (bit5..bit0).
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 Encodings SHALL be: interrupt 0x1, syscall 0x8, invalid 0xa, trap 0xd, overflow 0xc, eret 0xe, none 0x0.
REQ-018 Interrupt pending SHALL be: IE=1 and EXL=0 and ((int_i | {timer_int_i,5'b0}) & IM) != 0.
REQ-019 Event SHALL be sampled in IDLE only when mem_inst_valid_i=1; priority interrupt > syscall > invalid > trap > overflow > eret; lower events dropped that cycle.
REQ-020 FSM states IDLE, TAKE, DRAIN.
REQ-021 IDLE -> TAKE on a sampled event; otherwise stay IDLE.
REQ-022 TAKE lasts exactly 1 cycle: excepttype_o = encoding, flush_o=1, new_pc_o = cp0_epc_i (eret, captured at sample edge) else HANDLER_VEC; then -> DRAIN if FLUSH_CYCLES>1, else IDLE.
REQ-023 DRAIN: flush_o=1, new_pc_o held, excepttype_o=0, 3-bit counter counts to FLUSH_CYCLES-1 total flush cycles, then -> IDLE.
REQ-024 Latency: event sampled at edge N -> excepttype_o and flush_o high in cycle N+1; flush_o high cycles N+1..N+FLUSH_CYCLES; IDLE at N+FLUSH_CYCLES+1.
REQ-025 Events, interrupts and stall requests during TAKE/DRAIN SHALL be ignored (not queued).
REQ-026 stall_o in IDLE: stallreq_ex_i -> 6'b001111; else stallreq_id_i -> 6'b000111; else 0; combinational from inputs.
REQ-027 stall_o SHALL be 0 in TAKE and DRAIN (flush overrides stall).
REQ-028 Event coincident with stall request in IDLE: event taken; stall_o still driven that cycle per REQ-026.
REQ-029 All outputs except stall_o SHALL be registered.
REQ-030 eret sampled with EXL=0 SHALL still be taken (no EXL check).

Reset
REQ-031 rst=0 SHALL immediately force IDLE, counter 0, excepttype_o=0, flush_o=0, new_pc_o=0, busy_o=0, stall_o=0, regardless of clock.
REQ-032 Reset during TAKE/DRAIN aborts the sequence; first event after release is sampled normally.

Verification
REQ-033 Syscall: mem_excepttype_i=0x100, valid=1 -> next cycle excepttype_o=0x8, new_pc_o=0x20, flush_o high 2 cycles, busy_o high 2 cycles.
REQ-034 Priority: int_i[2]=1, IM bit12=1, IE=1, EXL=0, mem_excepttype_i=0x900 -> excepttype_o=0x1 only; no second event follows.
REQ-035 Masking: same interrupt with EXL=1, or mem_inst_valid_i=0 -> no excepttype_o, flush_o stays 0.
REQ-036 ERET: cp0_epc_i=0x00001234, bit12 set -> excepttype_o=0xe, new_pc_o=0x00001234 for both flush cycles.
REQ-037 Stall: stallreq_ex_i=1 and stallreq_id_i=1 in IDLE -> stall_o=6'b001111; during DRAIN with stallreq_id_i=1 -> stall_o=0.
REQ-038 Reset mid-DRAIN: drop rst asynchronously -> flush_o=0 same cycle; after release, overflow 0x800 -> excepttype_o=0xc one cycle later.
